// File: rtl/moore_ring_bank_pkg.sv
// Shared encodings for the armed Moore ring bank: per-channel command and step direction.
package moore_pkg;

   localparam logic [1:0] CMD_HOLD   = 2'b00;
   localparam logic [1:0] CMD_STEP   = 2'b01;
   localparam logic [1:0] CMD_ARM    = 2'b10;
   localparam logic [1:0] CMD_DISARM = 2'b11;

   localparam logic DIR_UP = 1'b0;

endpackage

// File: rtl/moore_ring_bank_cell.sv
// Single-channel armed Moore ring: NSTATES-state modulo counter stepped by a 2-bit
// command, with registered Moore output, armed flag and one-cycle wrap pulse.
module moore_ring_cell
   import moore_pkg::*;
#(
   parameter int                   NSTATES  = 4,
   parameter logic [NSTATES-1:0]   OUT_MASK = 4'b1010,
   localparam int                  SW       = $clog2(NSTATES)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [1:0]    cmd,
   input  logic          dir,
   output logic [SW-1:0] state,
   output logic          armed,
   output logic          out,
   output logic          wrap
);

   localparam logic [SW-1:0] LAST_STATE = SW'(NSTATES - 1);
   localparam logic [SW-1:0] ZERO_STATE = {SW{1'b0}};
   localparam logic [SW-1:0] ONE_STATE  = SW'(1);

   if (OUT_MASK[0] != 1'b0) begin : g_bad_mask
      $error("moore_ring_cell: OUT_MASK bit 0 must be 0 so the reset state drives out low");
   end

   // Moore decode by loop so any SW/NSTATES combination indexes the mask safely.
   function automatic logic mask_bit(input logic [SW-1:0] s);
      logic b;
      b = 1'b0;
      for (int k = 0; k < NSTATES; k++) begin
         if (32'(s) == 32'(k)) begin
            b = OUT_MASK[k];
         end else begin
            b = b;
         end
      end
      return b;
   endfunction

   logic [SW-1:0] state_r, state_nxt_s;
   logic          armed_r, armed_nxt_s;
   logic          out_r, wrap_r, wrap_nxt_s;
   logic          state_legal_s;

   assign state_legal_s = (32'(state_r) < 32'(NSTATES));

   // State register: synchronous active-low reset, out registered alongside state.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r <= ZERO_STATE;
         armed_r <= 1'b0;
         out_r   <= 1'b0;
         wrap_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         armed_r <= armed_nxt_s;
         out_r   <= mask_bit(state_nxt_s);
         wrap_r  <= wrap_nxt_s;
      end
   end

   // Next-state decode; an unreachable code is forced back to state 0 on any edge.
   always_comb begin
      state_nxt_s = state_r;
      armed_nxt_s = armed_r;
      wrap_nxt_s  = 1'b0;
      if (en) begin
         case (cmd)
            CMD_ARM: begin
               armed_nxt_s = 1'b1;
               state_nxt_s = ZERO_STATE;
            end
            CMD_DISARM: begin
               armed_nxt_s = 1'b0;
               state_nxt_s = ZERO_STATE;
            end
            CMD_STEP: begin
               if (!armed_r) begin
                  state_nxt_s = state_r;
               end else if (dir == DIR_UP) begin
                  if (state_r == LAST_STATE) begin
                     state_nxt_s = ZERO_STATE;
                     wrap_nxt_s  = 1'b1;
                  end else begin
                     state_nxt_s = state_r + ONE_STATE;
                  end
               end else begin
                  if (state_r == ZERO_STATE) begin
                     state_nxt_s = LAST_STATE;
                     wrap_nxt_s  = 1'b1;
                  end else begin
                     state_nxt_s = state_r - ONE_STATE;
                  end
               end
            end
            CMD_HOLD: begin
               state_nxt_s = state_r;
            end
            default: begin
               state_nxt_s = state_r;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
      end
      if (!state_legal_s) begin
         state_nxt_s = ZERO_STATE;
         wrap_nxt_s  = 1'b0;
      end else begin
         wrap_nxt_s  = wrap_nxt_s;
      end
   end

   // Output drive straight from registers.
   always_comb begin
      state = state_r;
      armed = armed_r;
      out   = out_r;
      wrap  = wrap_r;
   end

endmodule

// File: rtl/moore_ring_bank.sv
// Bank of CH independent armed Moore ring cells with packed per-channel buses.
module moore_ring_bank
   import moore_pkg::*;
#(
   parameter int                 CH       = 4,
   parameter int                 NSTATES  = 4,
   parameter logic [NSTATES-1:0] OUT_MASK = 4'b1010,
   localparam int                SW       = $clog2(NSTATES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [2*CH-1:0]  cmd,
   input  logic [CH-1:0]    dir,
   output logic [SW*CH-1:0] state_o,
   output logic [CH-1:0]    armed_o,
   output logic [CH-1:0]    out,
   output logic [CH-1:0]    wrap_o
);

   for (genvar i = 0; i < CH; i++) begin : g_ch
      moore_ring_cell #(
         .NSTATES  (NSTATES),
         .OUT_MASK (OUT_MASK)
      ) u_cell (
         .clk   (clk),
         .reset (reset),
         .en    (en),
         .cmd   (cmd[2*i+1:2*i]),
         .dir   (dir[i]),
         .state (state_o[SW*i+SW-1:SW*i]),
         .armed (armed_o[i]),
         .out   (out[i]),
         .wrap  (wrap_o[i])
      );
   end

endmodule
